// File: rtl/pmo_pkg.sv
// Shared touch FSM encoding, input indexing and default timing constants.
package pmo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TOUCH  = 2'd1,
      ST_PET    = 2'd2,
      ST_EXPECT = 2'd3
   } touch_state_e;

   // Defaults assume a 100 MHz clock
   localparam int unsigned DB_CYCLES_DEF          = 1_000_000;
   localparam int unsigned PET_HOLD_CYCLES_DEF    = 200_000_000;
   localparam int unsigned EXPECT_HOLD_CYCLES_DEF = 500_000_000;

   // Bit positions of the six conditioned inputs
   localparam int unsigned N_IN      = 6;
   localparam int unsigned IDX_TOUCH = 5;
   localparam int unsigned IDX_C     = 4;
   localparam int unsigned IDX_U     = 3;
   localparam int unsigned IDX_D     = 2;
   localparam int unsigned IDX_L     = 1;
   localparam int unsigned IDX_R     = 0;

   // Counter width for a terminal count of n-1; never narrower than one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/debounce_onepulse.sv
// Synchronise, debounce and edge-detect one asynchronous active-high input.
module debounce_onepulse
   import pmo_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int unsigned   CW       = cnt_w(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [1:0]    vld_q, vld_d;
   logic          arm_q, arm_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          prev_q, prev_d;
   logic          pulse_q, pulse_d;

   // Debounce counter, level toggle and rise detection.
   // A rise is only accepted once the input has been seen low since reset,
   // so an input held high across reset never produces a level or pulse.
   always_comb begin
      sync_d  = {sync_q[0], raw};
      vld_d   = {vld_q[0], 1'b1};
      arm_d   = arm_q | (vld_q[1] & ~sync_q[1]);
      level_d = level_q;
      cnt_d   = '0;
      prev_d  = level_q;
      pulse_d = level_q & ~prev_q;
      if ((sync_q[1] != level_q) && (arm_q || level_q)) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         vld_q   <= '0;
         arm_q   <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         vld_q   <= vld_d;
         arm_q   <= arm_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign level = level_q;
   assign pulse = pulse_q;

endmodule

// File: rtl/interaction_sensor.sv
// Touch-pad and five-way-button conditioning with touch-session classification.
module interaction_sensor
   import pmo_pkg::*;
#(
   parameter int unsigned DB_CYCLES          = DB_CYCLES_DEF,
   parameter int unsigned PET_HOLD_CYCLES    = PET_HOLD_CYCLES_DEF,
   parameter int unsigned EXPECT_HOLD_CYCLES = EXPECT_HOLD_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic touch_raw,
   input  logic btn_c_raw,
   input  logic btn_u_raw,
   input  logic btn_d_raw,
   input  logic btn_l_raw,
   input  logic btn_r_raw,
   output logic touched,
   output logic petting,
   output logic expecting,
   output logic awaking,
   output logic pressed,
   output logic up,
   output logic down,
   output logic left,
   output logic right
);

   localparam int unsigned   PW         = cnt_w(PET_HOLD_CYCLES);
   localparam int unsigned   EW         = cnt_w(EXPECT_HOLD_CYCLES);
   localparam int unsigned   HW         = (PW > EW) ? PW : EW;
   localparam logic [HW-1:0] PET_LAST   = HW'(PET_HOLD_CYCLES - 1);
   localparam logic [HW-1:0] EXPCT_LAST = HW'(EXPECT_HOLD_CYCLES - 1);

   logic [N_IN-1:0] raw_vec;
   logic [N_IN-1:0] lvl;
   logic [N_IN-1:0] pls;
   logic            t;

   touch_state_e    state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [N_IN-1:0] lvl_prev_q, lvl_prev_d;
   logic            awaking_q, awaking_d;
   logic            touched_q, touched_d;
   logic            petting_q, petting_d;
   logic            expecting_q, expecting_d;

   assign raw_vec = {touch_raw, btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw};

   // One conditioning channel per raw input
   for (genvar g = 0; g < N_IN; g++) begin : g_in
      debounce_onepulse #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_vec[g]),
         .level (lvl[g]),
         .pulse (pls[g])
      );
   end

   assign t = lvl[IDX_TOUCH];

   // Touch session next-state and shared hold counter
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (t) begin
               state_d = ST_TOUCH;
               hold_d  = '0;
            end
         end
         ST_TOUCH: begin
            if (!t) begin
               state_d = ST_IDLE;
            end else if (hold_q == PET_LAST) begin
               state_d = ST_PET;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         ST_PET: begin
            if (!t) begin
               state_d = ST_EXPECT;
               hold_d  = '0;
            end
         end
         ST_EXPECT: begin
            if (t) begin
               state_d = ST_TOUCH;
               hold_d  = '0;
            end else if (hold_q == EXPCT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // Level decode of the next state and combined rise pulse, aligned with the per-input pulses
   always_comb begin
      lvl_prev_d  = lvl;
      awaking_d   = |(lvl & ~lvl_prev_q);
      touched_d   = (state_d == ST_TOUCH) || (state_d == ST_PET);
      petting_d   = (state_d == ST_PET);
      expecting_d = (state_d == ST_EXPECT);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         lvl_prev_q  <= '0;
         awaking_q   <= 1'b0;
         touched_q   <= 1'b0;
         petting_q   <= 1'b0;
         expecting_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         lvl_prev_q  <= lvl_prev_d;
         awaking_q   <= awaking_d;
         touched_q   <= touched_d;
         petting_q   <= petting_d;
         expecting_q <= expecting_d;
      end
   end

   // The touch channel's own pulse has no consumer; awaking covers touch rises
   logic unused_touch_pulse;
   assign unused_touch_pulse = pls[IDX_TOUCH];

   assign touched   = touched_q;
   assign petting   = petting_q;
   assign expecting = expecting_q;
   assign awaking   = awaking_q;
   assign pressed   = pls[IDX_C];
   assign up        = pls[IDX_U];
   assign down      = pls[IDX_D];
   assign left      = pls[IDX_L];
   assign right     = pls[IDX_R];

endmodule

// File: tb/tb_interaction_sensor.sv
// Directed and randomized bench for interaction_sensor against a behavioural model.
module tb_interaction_sensor;
   import pmo_pkg::*;

   localparam int unsigned DB  = 4;
   localparam int unsigned PET = 20;
   localparam int unsigned EXP = 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic touch_raw = 1'b0, btn_c_raw = 1'b0, btn_u_raw = 1'b0;
   logic btn_d_raw = 1'b0, btn_l_raw = 1'b0, btn_r_raw = 1'b0;
   logic touched, petting, expecting, awaking, pressed, up, down, left, right;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   interaction_sensor #(
      .DB_CYCLES          (DB),
      .PET_HOLD_CYCLES    (PET),
      .EXPECT_HOLD_CYCLES (EXP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .touch_raw (touch_raw),
      .btn_c_raw (btn_c_raw),
      .btn_u_raw (btn_u_raw),
      .btn_d_raw (btn_d_raw),
      .btn_l_raw (btn_l_raw),
      .btn_r_raw (btn_r_raw),
      .touched   (touched),
      .petting   (petting),
      .expecting (expecting),
      .awaking   (awaking),
      .pressed   (pressed),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: a level flips once the last DB synchronised samples all
   // disagree with it (rises need the input to have been seen low since reset);
   // session levels follow from run lengths of the debounced touch level.
   logic [5:0] m_hist [0:DB];
   logic [5:0] m_lvl, m_lvlp, m_arm, m_pls;
   bit         m_awk, m_touched, m_petting, m_expecting, m_was_pet;
   int         m_edges, m_run1, m_run0;

   function automatic logic [5:0] raw_now();
      return {touch_raw, btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw};
   endfunction

   task automatic set_raw(input logic [5:0] v);
      {touch_raw, btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw} = v;
   endtask

   task automatic model_reset();
      for (int k = 0; k <= int'(DB); k++) m_hist[k] = '0;
      m_lvl = '0; m_lvlp = '0; m_arm = '0; m_pls = '0;
      m_awk = 0; m_touched = 0; m_petting = 0; m_expecting = 0; m_was_pet = 0;
      m_edges = 0; m_run1 = 0; m_run0 = 0;
   endtask

   task automatic model_step();
      logic [5:0] nl;
      logic [5:0] r;
      bit         tl;
      r  = raw_now();
      tl = m_lvl[IDX_TOUCH];
      for (int i = 0; i < 6; i++) begin
         bit flip;
         flip = m_lvl[i] || m_arm[i];
         for (int k = 1; k <= int'(DB); k++) if (m_hist[k][i] == m_lvl[i]) flip = 0;
         nl[i] = flip ? ~m_lvl[i] : m_lvl[i];
         if (m_edges >= 2 && !m_hist[1][i]) m_arm[i] = 1'b1;
      end
      for (int k = int'(DB); k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = r;
      m_pls  = m_lvl & ~m_lvlp;
      m_awk  = |m_pls;
      m_lvlp = m_lvl;
      m_lvl  = nl;
      m_edges++;
      if (tl) begin
         m_run0 = 0;
         if (m_run1 < int'(PET) + 1) m_run1++;
      end else begin
         if (m_run1 != 0) begin
            m_was_pet = (m_run1 >= int'(PET) + 1);
            m_run1    = 0;
         end
         if (m_run0 < int'(EXP) + 1) m_run0++;
      end
      m_touched   = tl;
      m_petting   = tl && (m_run1 >= int'(PET) + 1);
      m_expecting = !tl && m_was_pet && (m_run0 <= int'(EXP));
   endtask

   task automatic compare_all();
      check("touched",   int'(touched),   int'(m_touched));
      check("petting",   int'(petting),   int'(m_petting));
      check("expecting", int'(expecting), int'(m_expecting));
      check("awaking",   int'(awaking),   int'(m_awk));
      check("pressed",   int'(pressed),   int'(m_pls[IDX_C]));
      check("up",        int'(up),        int'(m_pls[IDX_U]));
      check("down",      int'(down),      int'(m_pls[IDX_D]));
      check("left",      int'(left),      int'(m_pls[IDX_L]));
      check("right",     int'(right),     int'(m_pls[IDX_R]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < cycles; i++) begin
         compare_all();
         @(negedge clk);
      end
      rst = 1'b1;
   endtask

   initial begin
      int cnt_a, cnt_b, at, t_rise, p_rise, same, exp_cnt, fell_ok;
      int dur [6];
      logic [5:0] rv;

      // Reset with every input held high; nothing may follow on release
      set_raw(6'h3f);
      #2;
      do_reset(5);
      cnt_a = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (awaking || touched || pressed) cnt_a++;
      end
      check("reset_held_quiet", cnt_a, 0);
      set_raw(6'h00);
      for (int i = 0; i < 15; i++) tick();

      // Bounce on the centre button, then a clean hold
      cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         btn_c_raw = ((i / 2) % 2) == 0;
         tick();
         if (pressed || awaking) cnt_a++;
      end
      check("bounce_quiet", cnt_a, 0);
      btn_c_raw = 1'b1;
      cnt_a = 0; cnt_b = 0; at = -1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (pressed) begin
            cnt_a++;
            if (at < 0) at = i;
         end
         if (awaking) cnt_b++;
      end
      check("bounce_pressed_count", cnt_a, 1);
      check("bounce_awaking_count", cnt_b, 1);
      check("bounce_latency", at, int'(DB) + 3);
      btn_c_raw = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      // Simultaneous up and left
      btn_u_raw = 1'b1; btn_l_raw = 1'b1;
      same = 0; cnt_b = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (up && left) same++;
         if (awaking) cnt_b++;
      end
      check("simul_same_cycle", same, 1);
      check("simul_awaking_count", cnt_b, 1);
      btn_u_raw = 1'b0; btn_l_raw = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      // Short touch
      touch_raw = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (touched) cnt_a++;
         if (petting) cnt_b++;
      end
      touch_raw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (touched) cnt_a++;
         if (petting || expecting) cnt_b++;
      end
      check("short_touched_cycles", cnt_a, 10);
      check("short_no_pet", cnt_b, 0);
      check("short_idle", int'(touched | petting | expecting), 0);

      // Pet then timeout
      touch_raw = 1'b1;
      t_rise = -1; p_rise = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (touched && t_rise < 0) t_rise = i;
         if (petting && p_rise < 0) p_rise = i;
      end
      check("pet_delay", p_rise - t_rise, int'(PET));
      touch_raw = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (expecting) exp_cnt++;
      end
      check("expect_length", exp_cnt, int'(EXP));
      check("timeout_idle", int'(touched | petting | expecting), 0);

      // Re-touch ten cycles into EXPECT
      touch_raw = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      touch_raw = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < 60 && exp_cnt < 10; i++) begin
         tick();
         if (expecting) exp_cnt++;
      end
      check("retouch_expect_reached", exp_cnt, 10);
      touch_raw = 1'b1;
      fell_ok = 0; t_rise = -1; p_rise = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!expecting && fell_ok == 0) fell_ok = touched ? 1 : 2;
         if (touched && t_rise < 0) t_rise = i;
         if (petting && p_rise < 0) p_rise = i;
      end
      check("retouch_same_edge", fell_ok, 1);
      check("retouch_fresh_pet", p_rise - t_rise, int'(PET));
      touch_raw = 1'b0;
      for (int i = 0; i < 50; i++) tick();

      // Randomized activity with a mid-run reset
      for (int j = 0; j < 6; j++) dur[j] = 0;
      rv = '0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset(3);
         end
         for (int j = 0; j < 6; j++) begin
            if (dur[j] == 0) begin
               rv[j]  = ~rv[j];
               dur[j] = (j == int'(IDX_TOUCH)) ? int'($urandom_range(1, 70))
                                               : int'($urandom_range(1, 10));
            end
            dur[j]--;
         end
         set_raw(rv);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
